// File: rtl/can_rx_hexfmt.sv
// Formats captured CAN frames as ASCII "ID:DATA" lines toward a UART transmitter.
// Frames arriving while a line is still being printed are discarded and counted.
module can_rx_hexfmt #(
  parameter int UPPER_HEX = 1,
  parameter int CRLF      = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic [7:0]  rx_data,
  input  logic [28:0] rx_id,
  input  logic        rx_ide,
  output logic        tx_en,
  input  logic        tx_rdy,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [2:0] S_CAPTURE = 3'd0;
  localparam logic [2:0] S_ID      = 3'd1;
  localparam logic [2:0] S_COLON   = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CR      = 3'd5;
  localparam logic [2:0] S_LF      = 3'd6;
  localparam logic [2:0] S_DROP    = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [7:0]  r_buf [8];
  logic [28:0] r_id;
  logic        r_ide;
  logic        r_disc;
  logic [7:0]  r_drop_cnt;
  logic        r_tx_en;
  logic [7:0]  r_tx_data;
  logic        r_busy;

  logic        w_hs;
  logic        w_lf_done;
  logic [2:0]  w_state_nxt;
  logic [2:0]  w_ptr_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_disc_nxt;
  logic        w_drop_inc;
  logic        w_store;
  logic        w_latch;
  logic [28:0] w_id_nxt;
  logic        w_ide_nxt;
  logic [31:0] w_id32;
  logic [7:0]  w_char_nxt;
  logic        w_emit_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else if (UPPER_HEX != 0) begin
      c = 8'h37 + {4'h0, nib};   // 10 maps to 'A'
    end else begin
      c = 8'h57 + {4'h0, nib};   // 10 maps to 'a'
    end
    return c;
  endfunction

  assign w_hs      = r_tx_en & tx_rdy;
  assign w_lf_done = (r_state == S_LF) & w_hs;

  // Next-state, capture counter and discard tracking
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_disc_nxt  = r_disc;
    w_drop_inc  = 1'b0;
    w_store     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_CAPTURE: begin
        if (rx_valid) begin
          w_store   = (r_cnt < 4'd8);
          w_cnt_nxt = (r_cnt < 4'd8) ? r_cnt + 4'd1 : r_cnt;
          if (rx_last) begin
            w_latch     = 1'b1;
            w_state_nxt = S_ID;
            w_ptr_nxt   = rx_ide ? 3'd7 : 3'd2;
          end else begin
            w_latch     = 1'b0;
          end
        end else begin
          w_store = 1'b0;
        end
      end
      S_ID: begin
        if (w_hs) begin
          if (r_ptr == 3'd0) begin
            w_state_nxt = S_COLON;
          end else begin
            w_ptr_nxt = r_ptr - 3'd1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_COLON: begin
        if (w_hs) begin
          w_state_nxt = S_DATA_HI;
          w_ptr_nxt   = 3'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DATA_HI: w_state_nxt = w_hs ? S_DATA_LO : r_state;
      S_DATA_LO: begin
        if (w_hs) begin
          if (({1'b0, r_ptr} + 4'd1) >= r_cnt) begin
            w_state_nxt = (CRLF != 0) ? S_CR : S_LF;
          end else begin
            w_state_nxt = S_DATA_HI;
            w_ptr_nxt   = r_ptr + 3'd1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_CR: w_state_nxt = w_hs ? S_LF : r_state;
      S_LF: w_state_nxt = r_state;
      S_DROP: begin
        if (rx_valid & rx_last) begin
          w_state_nxt = S_CAPTURE;
          w_drop_inc  = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_CAPTURE;
        w_ptr_nxt   = 3'd0;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // A frame seen while printing is discarded; the flag outlives the line via DROP.
    if (r_busy) begin
      if (rx_valid) begin
        w_drop_inc = rx_last;
        w_disc_nxt = ~rx_last;
      end else begin
        w_disc_nxt = r_disc;
      end
      w_state_nxt = w_lf_done ? (w_disc_nxt ? S_DROP : S_CAPTURE) : w_state_nxt;
      w_cnt_nxt   = w_lf_done ? 4'd0 : w_cnt_nxt;
      w_disc_nxt  = w_lf_done ? 1'b0 : w_disc_nxt;
    end else begin
      w_disc_nxt = 1'b0;
    end
  end

  // Character for the next cycle, so tx_en/tx_data leave straight from flops
  always_comb begin
    w_id_nxt   = w_latch ? rx_id  : r_id;
    w_ide_nxt  = w_latch ? rx_ide : r_ide;
    w_id32     = w_ide_nxt ? {3'b000, w_id_nxt} : {21'd0, w_id_nxt[10:0]};
    w_char_nxt = 8'h00;
    w_emit_nxt = 1'b1;
    case (w_state_nxt)
      S_ID:      w_char_nxt = hex_char(w_id32[{w_ptr_nxt, 2'b00} +: 4]);
      S_COLON:   w_char_nxt = 8'h3A;
      S_DATA_HI: w_char_nxt = hex_char(r_buf[w_ptr_nxt][7:4]);
      S_DATA_LO: w_char_nxt = hex_char(r_buf[w_ptr_nxt][3:0]);
      S_CR:      w_char_nxt = 8'h0D;
      S_LF:      w_char_nxt = 8'h0A;
      default: begin
        w_char_nxt = 8'h00;
        w_emit_nxt = 1'b0;
      end
    endcase
  end

  // Control state, latched ID and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_CAPTURE;
      r_ptr      <= 3'd0;
      r_cnt      <= 4'd0;
      r_id       <= 29'd0;
      r_ide      <= 1'b0;
      r_disc     <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_id       <= w_id_nxt;
      r_ide      <= w_ide_nxt;
      r_disc     <= w_disc_nxt;
      r_drop_cnt <= (w_drop_inc && (r_drop_cnt != 8'hFF)) ? r_drop_cnt + 8'd1 : r_drop_cnt;
      r_tx_en    <= w_emit_nxt;
      r_tx_data  <= w_char_nxt;
      r_busy     <= w_emit_nxt;
    end
  end

  // Payload buffer, written only while capturing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else if (w_store) begin
      r_buf[r_cnt[2:0]] <= rx_data;
    end
  end

  assign tx_en    = r_tx_en;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_can_rx_hexfmt.sv
// Scoreboard bench for can_rx_hexfmt: default instance plus a lowercase/LF-only instance.
module tb_can_rx_hexfmt;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid, rx_valid2, rx_last;
  logic [7:0]  rx_data;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic        tx_rdy;
  logic        tx_en, tx_en2, busy, busy2;
  logic [7:0]  tx_data, tx_data2, drop_cnt, drop_cnt2;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  int          n1, n2, first1, first2, last1, last2, t_last;
  bit          rdy_rand;
  logic [7:0]  fb [10];

  can_rx_hexfmt dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_last(rx_last), .rx_data(rx_data),
    .rx_id(rx_id), .rx_ide(rx_ide), .tx_en(tx_en), .tx_rdy(tx_rdy), .tx_data(tx_data),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  can_rx_hexfmt #(.UPPER_HEX(0), .CRLF(0)) dut2 (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid2), .rx_last(rx_last), .rx_data(rx_data),
    .rx_id(rx_id), .rx_ide(rx_ide), .tx_en(tx_en2), .tx_rdy(tx_rdy), .tx_data(tx_data2),
    .busy(busy2), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_line(input bit which, input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) begin
      if (which) q2.push_back(s[i]); else q1.push_back(s[i]);
    end
    if (crlf) q1.push_back(8'h0D);
    if (which) q2.push_back(8'h0A); else q1.push_back(8'h0A);
  endtask

  task automatic drv(input bit which, input logic [7:0] d, input bit last,
                     input logic [28:0] id, input bit ide);
    @(posedge clk); #1;
    rx_valid  = !which;
    rx_valid2 = which;
    rx_last   = last;
    rx_data   = d;
    rx_id     = id;
    rx_ide    = ide;
    if (last) t_last = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_valid2 = 1'b0; rx_last = 1'b0;
    end
  endtask

  task automatic send(input bit which, input logic [28:0] id, input bit ide, input int n);
    for (int i = 0; i < n; i++) drv(which, fb[i], (i == n - 1), id, ide);
    idle(1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((q1.size() != 0 || q2.size() != 0 || busy || busy2 || rx_valid) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_timeout"}, 32'(t < 5000), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  // Pops the expected character on every handshake; also checks stall stability.
  task automatic monitor();
    logic [7:0] held1, held2, e;
    bit stall1 = 1'b0;
    bit stall2 = 1'b0;
    forever begin
      @(negedge clk);
      if (stall1 && tx_en) chk("dut1_stall_stable", {24'd0, tx_data}, {24'd0, held1});
      stall1 = tx_en && !tx_rdy;
      held1  = tx_data;
      if (stall2 && tx_en2) chk("dut2_stall_stable", {24'd0, tx_data2}, {24'd0, held2});
      stall2 = tx_en2 && !tx_rdy;
      held2  = tx_data2;
      if (tx_en && tx_rdy) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut1_unexpected_char actual=%0h expected=none", tx_data);
        end else begin
          e = q1.pop_front();
          chk("dut1_char", {24'd0, tx_data}, {24'd0, e});
        end
        if (n1 == 0) first1 = cyc;
        last1 = cyc;
        n1++;
      end
      if (tx_en2 && tx_rdy) begin
        if (q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut2_unexpected_char actual=%0h expected=none", tx_data2);
        end else begin
          e = q2.pop_front();
          chk("dut2_char", {24'd0, tx_data2}, {24'd0, e});
        end
        if (n2 == 0) first2 = cyc;
        last2 = cyc;
        n2++;
      end
    end
  endtask

  task automatic rdy_gen();
    forever begin
      @(posedge clk); #1;
      tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    int t;
    rstn = 1'b0; rx_valid = 1'b0; rx_valid2 = 1'b0; rx_last = 1'b0;
    rx_data = 8'h00; rx_id = 29'd0; rx_ide = 1'b0; tx_rdy = 1'b1; rdy_rand = 1'b0;
    n1 = 0; n2 = 0; first1 = 0; first2 = 0; last1 = 0; last2 = 0; t_last = 0;
    fork
      monitor();
      rdy_gen();
    join_none
    #12;
    chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);

    // Standard ID, four bytes, back-to-back output
    n1 = 0;
    exp_line(0, "123:01020304", 1);
    for (int i = 0; i < 4; i++) fb[i] = 8'(i + 1);
    send(0, 29'h123, 1'b0, 4);
    wait_idle("s1");
    chk("s1_latency", first1, t_last + 1);
    chk("s1_span", last1 - first1, 32'd13);
    chk("s1_chars", n1, 32'd14);

    // Extended ID on the lowercase/LF-only instance
    n2 = 0;
    exp_line(1, "12345678:ab", 0);
    fb[0] = 8'hAB;
    send(1, 29'h12345678, 1'b1, 1);
    wait_idle("s2");
    chk("s2_latency", first2, t_last + 1);
    chk("s2_chars", n2, 32'd12);

    // Eight bytes with a randomly stalling UART
    n1 = 0;
    rdy_rand = 1'b1;
    exp_line(0, "7FF:FFFFFFFFFFFFFFFF", 1);
    for (int i = 0; i < 8; i++) fb[i] = 8'hFF;
    send(0, 29'h7FF, 1'b0, 8);
    wait_idle("s3");
    rdy_rand = 1'b0;
    chk("s3_chars", n1, 32'd22);

    // Ten bytes: only the first eight print; upper ID bits ignored for standard frames
    exp_line(0, "001:0001020304050607", 1);
    for (int i = 0; i < 10; i++) fb[i] = 8'(i);
    send(0, 29'h1ABCD001, 1'b0, 10);
    wait_idle("s5");
    chk("s5_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Frame arriving during a print is dropped
    exp_line(0, "100:55", 1);
    fb[0] = 8'h55;
    send(0, 29'h100, 1'b0, 1);
    drv(0, 8'h66, 1'b0, 29'h200, 1'b0);
    drv(0, 8'h77, 1'b1, 29'h200, 1'b0);
    idle(1);
    wait_idle("s4a");
    chk("s4a_drop_cnt", {24'd0, drop_cnt}, 32'd1);

    // Dropped frame ends after the print finishes; next frame prints normally
    exp_line(0, "300:01", 1);
    fb[0] = 8'h01;
    send(0, 29'h300, 1'b0, 1);
    drv(0, 8'hEE, 1'b0, 29'h3FF, 1'b0);
    idle(20);
    chk("s4b_busy_in_drop", {31'd0, busy}, 32'd0);
    chk("s4b_queue_empty", q1.size(), 32'd0);
    drv(0, 8'hDD, 1'b1, 29'h3FF, 1'b0);
    idle(1);
    chk("s4b_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    exp_line(0, "301:9A", 1);
    fb[0] = 8'h9A;
    send(0, 29'h301, 1'b0, 1);
    wait_idle("s4c");
    chk("s4c_drop_cnt", {24'd0, drop_cnt}, 32'd2);

    // Reset in the middle of the data field, then a full repeat
    n1 = 0;
    exp_line(0, "123:01020304", 1);
    for (int i = 0; i < 4; i++) fb[i] = 8'(i + 1);
    send(0, 29'h123, 1'b0, 4);
    t = 0;
    while (n1 < 6 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("s6_reach_data", 32'(t < 100), 32'd1);
    #1;
    rstn = 1'b0;
    q1.delete();
    #1;
    chk("s6_rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("s6_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("s6_rst_busy", {31'd0, busy}, 32'd0);
    chk("s6_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    idle(3);
    rstn = 1'b1;
    idle(2);
    n1 = 0;
    exp_line(0, "123:01020304", 1);
    send(0, 29'h123, 1'b0, 4);
    wait_idle("s6");
    chk("s6_chars", n1, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
